// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot loader.
// Holds the loader and UART receiver state enums, the image framing
// constants, and a helper that assembles the 16-bit word-count header.
package boot_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_WORD = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } load_state_t;

    // UART receiver states.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Number of header bytes that carry the word count.
    localparam int LEN_BYTES      = 2;
    // Bytes per instruction word.
    localparam int BYTES_PER_WORD = 4;

    // The header arrives low byte first.
    function automatic logic [15:0] make_len(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// Synchronises the asynchronous serial line, detects the start bit,
// rejects start-bit glitches at mid-bit, and samples 8 data bits LSB first
// followed by the stop bit.
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx_i       serial input, idle high, asynchronous to clk
//   byte_valid one-cycle pulse when a byte with a valid stop bit is received
//   byte_data  received byte, valid while byte_valid is high
//   frame_err  one-cycle pulse when the stop bit is sampled low
module uart_rx
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic            rx_meta_r;
    logic            rx_sync_r;
    logic            rx_prev_r;
    rx_state_t       state_r;
    rx_state_t       state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [2:0]      bit_idx_r;
    logic [2:0]      bit_idx_next_s;
    logic [7:0]      shift_r;
    logic [7:0]      shift_next_s;
    logic            byte_valid_r;
    logic            byte_valid_next_s;
    logic [7:0]      byte_data_r;
    logic [7:0]      byte_data_next_s;
    logic            frame_err_r;
    logic            frame_err_next_s;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_i;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= RX_IDLE;
            cnt_r        <= '0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            byte_valid_r <= 1'b0;
            byte_data_r  <= 8'h00;
            frame_err_r  <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            bit_idx_r    <= bit_idx_next_s;
            shift_r      <= shift_next_s;
            byte_valid_r <= byte_valid_next_s;
            byte_data_r  <= byte_data_next_s;
            frame_err_r  <= frame_err_next_s;
        end
    end

    // Next-state and bit-timing logic.
    always_comb begin
        state_next_s      = state_r;
        cnt_next_s        = cnt_r;
        bit_idx_next_s    = bit_idx_r;
        shift_next_s      = shift_r;
        byte_valid_next_s = 1'b0;
        byte_data_next_s  = byte_data_r;
        frame_err_next_s  = 1'b0;
        case (state_r)
            RX_IDLE: begin
                cnt_next_s     = '0;
                bit_idx_next_s = 3'd0;
                if (rx_prev_r && !rx_sync_r) begin
                    state_next_s = RX_START;
                end else begin
                    state_next_s = RX_IDLE;
                end
            end
            RX_START: begin
                // Re-check the line half a bit in; a high line was a glitch.
                if (cnt_r == HALF_CNT) begin
                    cnt_next_s = '0;
                    if (rx_sync_r) begin
                        state_next_s = RX_IDLE;
                    end else begin
                        state_next_s = RX_DATA;
                    end
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1'b1);
                end
            end
            RX_DATA: begin
                if (cnt_r == FULL_CNT) begin
                    cnt_next_s     = '0;
                    shift_next_s   = {rx_sync_r, shift_r[7:1]};
                    bit_idx_next_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        state_next_s = RX_STOP;
                    end else begin
                        state_next_s = RX_DATA;
                    end
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1'b1);
                end
            end
            RX_STOP: begin
                if (cnt_r == FULL_CNT) begin
                    cnt_next_s   = '0;
                    state_next_s = RX_IDLE;
                    if (rx_sync_r) begin
                        byte_valid_next_s = 1'b1;
                        byte_data_next_s  = shift_r;
                    end else begin
                        frame_err_next_s = 1'b1;
                    end
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1'b1);
                end
            end
            default: begin
                state_next_s = RX_IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    assign byte_valid = byte_valid_r;
    assign byte_data  = byte_data_r;
    assign frame_err  = frame_err_r;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader for the single-cycle RV32I core.
// Receives a 2-byte little-endian word count followed by that many
// little-endian 32-bit words, writes each word into instruction memory and
// releases the core from reset once the whole image is in.
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx_i       UART serial input (8N1, idle high)
//   load_en    one-cycle instruction-memory write strobe
//   load_data  assembled instruction word
//   load_addr  word address of load_data
//   core_rst   core reset, held high until the image is complete
//   done       image fully loaded (sticky)
//   err        framing or length error (sticky)
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int MAX_WORDS    = 256,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    output logic              load_en,
    output logic [31:0]       load_data,
    output logic [ADDR_W-1:0] load_addr,
    output logic              core_rst,
    output logic              done,
    output logic              err
);

    localparam int HDR_BITS = LEN_BYTES * 8;

    logic                byte_valid_s;
    logic [7:0]          byte_data_s;
    logic                frame_err_s;

    load_state_t         state_r;
    load_state_t         state_next_s;
    logic [7:0]          len_lo_r;
    logic [7:0]          len_lo_next_s;
    logic [HDR_BITS-1:0] len_r;
    logic [HDR_BITS-1:0] len_next_s;
    logic [HDR_BITS-1:0] len_full_s;
    logic [1:0]          byte_idx_r;
    logic [1:0]          byte_idx_next_s;
    logic [ADDR_W:0]     word_idx_r;
    logic [ADDR_W:0]     word_idx_next_s;
    logic [ADDR_W:0]     word_inc_s;
    // Lanes for bytes 0..2; byte 3 goes straight into load_data.
    logic [2:0][7:0]     lanes_r;
    logic [2:0][7:0]     lanes_next_s;

    logic                load_en_r;
    logic                load_en_next_s;
    logic [31:0]         load_data_r;
    logic [31:0]         load_data_next_s;
    logic [ADDR_W-1:0]   load_addr_r;
    logic [ADDR_W-1:0]   load_addr_next_s;
    logic                core_rst_r;
    logic                core_rst_next_s;
    logic                done_r;
    logic                done_next_s;
    logic                err_r;
    logic                err_next_s;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx_i      (rx_i),
        .byte_valid(byte_valid_s),
        .byte_data (byte_data_s),
        .frame_err (frame_err_s)
    );

    assign len_full_s = make_len(byte_data_s, len_lo_r);
    assign word_inc_s = word_idx_r + {{ADDR_W{1'b0}}, 1'b1};

    // Loader state, counters, lanes and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_LEN0;
            len_lo_r    <= 8'h00;
            len_r       <= '0;
            byte_idx_r  <= 2'd0;
            word_idx_r  <= '0;
            lanes_r     <= '0;
            load_en_r   <= 1'b0;
            load_data_r <= 32'h0000_0000;
            load_addr_r <= '0;
            core_rst_r  <= 1'b1;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            len_lo_r    <= len_lo_next_s;
            len_r       <= len_next_s;
            byte_idx_r  <= byte_idx_next_s;
            word_idx_r  <= word_idx_next_s;
            lanes_r     <= lanes_next_s;
            load_en_r   <= load_en_next_s;
            load_data_r <= load_data_next_s;
            load_addr_r <= load_addr_next_s;
            core_rst_r  <= core_rst_next_s;
            done_r      <= done_next_s;
            err_r       <= err_next_s;
        end
    end

    // Loader next-state, byte assembly and output logic.
    always_comb begin
        state_next_s     = state_r;
        len_lo_next_s    = len_lo_r;
        len_next_s       = len_r;
        byte_idx_next_s  = byte_idx_r;
        word_idx_next_s  = word_idx_r;
        lanes_next_s     = lanes_r;
        load_en_next_s   = 1'b0;
        load_data_next_s = load_data_r;
        load_addr_next_s = load_addr_r;
        done_next_s      = done_r;
        case (state_r)
            S_LEN0: begin
                if (byte_valid_s) begin
                    len_lo_next_s = byte_data_s;
                    state_next_s  = S_LEN1;
                end else if (frame_err_s) begin
                    state_next_s = S_ERR;
                end else begin
                    state_next_s = S_LEN0;
                end
            end
            S_LEN1: begin
                if (byte_valid_s) begin
                    len_next_s = len_full_s;
                    if (len_full_s == '0) begin
                        // Empty image: release the core on the next cycle.
                        state_next_s = S_DONE;
                        done_next_s  = 1'b1;
                    end else if (len_full_s > HDR_BITS'(MAX_WORDS)) begin
                        state_next_s = S_ERR;
                    end else begin
                        state_next_s    = S_WORD;
                        byte_idx_next_s = 2'd0;
                        word_idx_next_s = '0;
                    end
                end else if (frame_err_s) begin
                    state_next_s = S_ERR;
                end else begin
                    state_next_s = S_LEN1;
                end
            end
            S_WORD: begin
                if (byte_valid_s) begin
                    byte_idx_next_s = byte_idx_r + 2'd1;
                    case (byte_idx_r)
                        2'd0: lanes_next_s[0] = byte_data_s;
                        2'd1: lanes_next_s[1] = byte_data_s;
                        2'd2: lanes_next_s[2] = byte_data_s;
                        default: lanes_next_s = lanes_r;
                    endcase
                    if (byte_idx_r == 2'(BYTES_PER_WORD - 1)) begin
                        load_en_next_s   = 1'b1;
                        load_data_next_s = {byte_data_s, lanes_r[2], lanes_r[1], lanes_r[0]};
                        load_addr_next_s = word_idx_r[ADDR_W-1:0];
                        word_idx_next_s  = word_inc_s;
                        // Enter S_DONE together with the final strobe.
                        if (HDR_BITS'(word_inc_s) == len_r) begin
                            state_next_s = S_DONE;
                        end else begin
                            state_next_s = S_WORD;
                        end
                    end else begin
                        state_next_s = S_WORD;
                    end
                end else if (frame_err_s) begin
                    state_next_s = S_ERR;
                end else begin
                    state_next_s = S_WORD;
                end
            end
            S_DONE: begin
                state_next_s = S_DONE;
                done_next_s  = 1'b1;
            end
            S_ERR: begin
                state_next_s = S_ERR;
            end
            default: begin
                state_next_s = S_ERR;
            end
        endcase
        err_next_s      = err_r | (state_next_s == S_ERR);
        core_rst_next_s = ~done_next_s;
    end

    assign load_en   = load_en_r;
    assign load_data = load_data_r;
    assign load_addr = load_addr_r;
    assign core_rst  = core_rst_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed testbench for uart_boot_loader with CLKS_PER_BIT=4.
module tb_uart_boot_loader;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_i = 1'b1;
    logic        load_en;
    logic [31:0] load_data;
    logic [7:0]  load_addr;
    logic        core_rst;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;

    logic [7:0]  addr_q[$];
    logic [31:0] data_q[$];
    logic        rst_at_q[$];
    logic        rst_after_q[$];
    logic        done_after_bv_q[$];
    int          bv_count = 0;
    int          back_to_back = 0;
    logic        prev_le = 1'b0;
    logic        prev_bv = 1'b0;

    uart_boot_loader #(
        .CLKS_PER_BIT(CPB),
        .MAX_WORDS   (256),
        .ADDR_W      (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_i     (rx_i),
        .load_en  (load_en),
        .load_data(load_data),
        .load_addr(load_addr),
        .core_rst (core_rst),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Capture strobes and status just after each active edge.
    always @(posedge clk) begin
        #1;
        if (prev_le) rst_after_q.push_back(core_rst);
        if (prev_bv) done_after_bv_q.push_back(done);
        if (load_en) begin
            if (prev_le) back_to_back = back_to_back + 1;
            addr_q.push_back(load_addr);
            data_q.push_back(load_data);
            rst_at_q.push_back(core_rst);
        end
        if (dut.u_rx.byte_valid) bv_count = bv_count + 1;
        prev_le = load_en;
        prev_bv = dut.u_rx.byte_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst  = 1'b1;
        rx_i = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        addr_q.delete();
        data_q.delete();
        rst_at_q.delete();
        rst_after_q.delete();
        done_after_bv_q.delete();
        bv_count = 0;
        back_to_back = 0;
    endtask

    task automatic bit_time(input logic v);
        rx_i = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop_ok);
        bit_time(1'b1);
    endtask

    initial begin
        // Reset state
        reset_dut();
        check("rst_load_en", {31'd0, load_en}, 32'd0);
        check("rst_load_data", load_data, 32'h0000_0000);
        check("rst_load_addr", {24'd0, load_addr}, 32'd0);
        check("rst_core_rst", {31'd0, core_rst}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);

        // Two-word image
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h93, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h50, 1'b1); send_byte(8'h00, 1'b1);
        check("img2_core_rst_mid", {31'd0, core_rst}, 32'd1);
        send_byte(8'h13, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'hA0, 1'b1); send_byte(8'h00, 1'b1);
        repeat (8) @(negedge clk);
        check("img2_strobes", addr_q.size(), 32'd2);
        if (addr_q.size() == 2) begin
            check("img2_addr0", {24'd0, addr_q[0]}, 32'd0);
            check("img2_data0", data_q[0], 32'h0050_0093);
            check("img2_addr1", {24'd0, addr_q[1]}, 32'd1);
            check("img2_data1", data_q[1], 32'h00A0_0113);
            check("img2_rst_at_last", {31'd0, rst_at_q[1]}, 32'd1);
            check("img2_rst_after_last", {31'd0, rst_after_q[1]}, 32'd0);
        end
        check("img2_done", {31'd0, done}, 32'd1);
        check("img2_err", {31'd0, err}, 32'd0);
        check("img2_hold_data", load_data, 32'h00A0_0113);
        check("img2_back_to_back", back_to_back, 32'd0);
        // Bytes after completion are ignored
        send_byte(8'h55, 1'b1);
        check("img2_ignore_strobes", addr_q.size(), 32'd2);

        // Zero-length image
        reset_dut();
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        check("len0_bytes", done_after_bv_q.size(), 32'd2);
        if (done_after_bv_q.size() == 2) begin
            check("len0_done_after_b0", {31'd0, done_after_bv_q[0]}, 32'd0);
            check("len0_done_after_b1", {31'd0, done_after_bv_q[1]}, 32'd1);
        end
        check("len0_core_rst", {31'd0, core_rst}, 32'd0);
        check("len0_strobes", addr_q.size(), 32'd0);

        // Oversize length 257
        reset_dut();
        send_byte(8'h01, 1'b1); send_byte(8'h01, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'hA5, 1'b1);
        check("len257_err", {31'd0, err}, 32'd1);
        check("len257_core_rst", {31'd0, core_rst}, 32'd1);
        check("len257_done", {31'd0, done}, 32'd0);
        check("len257_strobes", addr_q.size(), 32'd0);

        // Framing error on the third data byte
        reset_dut();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b1);
        check("ferr_err", {31'd0, err}, 32'd1);
        check("ferr_done", {31'd0, done}, 32'd0);
        check("ferr_core_rst", {31'd0, core_rst}, 32'd1);
        check("ferr_strobes", addr_q.size(), 32'd0);

        // Start-bit glitch, then a normal one-word image
        reset_dut();
        rx_i = 1'b0;
        @(negedge clk);
        rx_i = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_bytes", bv_count, 32'd0);
        check("glitch_err", {31'd0, err}, 32'd0);
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
        check("glitch_strobes", addr_q.size(), 32'd1);
        if (addr_q.size() == 1) check("glitch_data", data_q[0], 32'h1234_5678);
        check("glitch_done", {31'd0, done}, 32'd1);

        // Reset in the middle of word 0, then a fresh image
        reset_dut();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        check("midrst_no_strobe", addr_q.size(), 32'd0);
        reset_dut();
        check("midrst_data_cleared", load_data, 32'h0000_0000);
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1);
        send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
        repeat (4) @(negedge clk);
        check("midrst_strobes", addr_q.size(), 32'd1);
        if (addr_q.size() == 1) begin
            check("midrst_addr", {24'd0, addr_q[0]}, 32'd0);
            check("midrst_data", data_q[0], 32'hDEAD_BEEF);
        end
        check("midrst_done", {31'd0, done}, 32'd1);
        check("midrst_core_rst", {31'd0, core_rst}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Upstream feeder for the single-cycle RV32I core.
- Receives a program image over a UART line (8N1) and assembles little-endian bytes into 32-bit instruction words.
- Drives the core's instruction-memory write path (`load_en`, `load_data`, `load_addr`).
- Holds the core in reset until the image is complete, then releases it.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 4.
- MAX_WORDS, 256, instruction-memory depth in words.
- ADDR_W, 8, width of the word address (log2 MAX_WORDS).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx_i  input  1  UART serial input, idle high, asynchronous to clk
- load_en  output  1  one-cycle write strobe to instruction memory
- load_data  output  32  assembled instruction word
- load_addr  output  ADDR_W  word address of load_data
- core_rst  output  1  reset to the core; high while loading
- done  output  1  image fully loaded (sticky)
- err  output  1  framing or length error (sticky)

Behaviour:
- Single clock domain: clk. rst is synchronous and active-high.
- Reset values: load_en=0, load_data=0, load_addr=0, core_rst=1, done=0, err=0, FSM=S_LEN0, all counters=0.
- rx_i synchronisation: two-flop synchroniser before any use.
- UART RX sub-module states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronised 1->0 edge.
  - START: at CLKS_PER_BIT/2 cycles, re-sample the line. If high, treat as a glitch and return to IDLE with no byte. If low, go to DATA.
  - DATA: sample 8 bits LSB first, each CLKS_PER_BIT cycles after the previous sample point.
  - STOP: sample the stop bit after CLKS_PER_BIT cycles.
    - Stop bit high: byte_valid pulses for 1 cycle with byte_data.
    - Stop bit low: frame_err pulses for 1 cycle and the byte is discarded.
  - Return to IDLE immediately after the stop-bit sample.
- Image protocol:
  - Byte 0 = LEN[7:0], byte 1 = LEN[15:8], where LEN is the word count.
  - Followed by LEN words, 4 bytes each, least-significant byte first.
- Loader FSM states: S_LEN0, S_LEN1, S_WORD, S_DONE, S_ERR.
  - S_LEN0 -> S_LEN1 on byte_valid; store LEN low byte.
  - S_LEN1 on byte_valid, evaluate the full LEN:
    - LEN=0 -> S_DONE.
    - LEN>MAX_WORDS -> S_ERR.
    - Otherwise -> S_WORD with byte index 0 and word index 0.
  - S_WORD: each byte_valid shifts the byte into lane[index] and increments the 2-bit index.
    - In the cycle after the 4th byte's byte_valid: load_en=1, load_data={b3,b2,b1,b0}, load_addr=word index.
    - The word index increments after each load_en.
    - When the word index reaches LEN, move to S_DONE in the same cycle that load_en is asserted.
  - S_DONE: core_rst=0 and done=1 from the cycle after the final load_en (or after LEN=0 is evaluated). Further bytes are ignored. Exit only via rst.
  - S_ERR: err=1, core_rst stays 1, load_en is never asserted. Exit only via rst.
- A frame_err in S_LEN0, S_LEN1 or S_WORD moves the FSM to S_ERR. A frame_err in S_DONE is ignored.
- load_data and load_addr hold their last values between strobes.
- load_en is never asserted in consecutive cycles (bytes are at least 10 bit-times apart).
- rst asserted mid-image: everything returns to reset values. A partial word is discarded and never written.
- A byte_valid arriving in the same cycle as rst is dropped.

Decomposition:
- Shared package `boot_pkg`:
  - Loader FSM state enum.
  - UART RX state enum.
  - LEN header byte count (2).
  - Bytes per word (4).
- Sub-module `uart_rx`, with ports clk, rst, rx_i, byte_valid, byte_data[7:0], frame_err, parameter CLKS_PER_BIT.
  - It contains the synchroniser and the RX FSM.
  - The top level contains the loader FSM, byte lanes and word counter.

Test Plan (CLKS_PER_BIT=4, MAX_WORDS=256):
- Send bytes 02 00, 93 00 50 00, 13 01 A0 00 -> load_en at addr 0 with 0x00500093, then at addr 1 with 0x00A00113. core_rst falls the cycle after the second strobe. done=1, err=0.
- Send LEN 00 00 -> no load_en. done=1 and core_rst=0 one cycle after the second byte is accepted.
- Send LEN 01 01 (257) -> err=1, core_rst stays 1. Following bytes produce no load_en.
- In the 3rd data byte, drive the stop bit low -> err=1, no load_en for that word, done remains 0.
- Pull rx_i low for 1 cycle (shorter than half a bit) -> no byte_valid, FSM stays in S_LEN0. A following valid LEN byte is accepted normally.
- Assert rst after 2 of 4 bytes of word 0, then send a full 1-word image 01 00 EF BE AD DE -> a single load_en at addr 0 with 0xDEADBEEF. No stale byte lanes appear in load_data.
